// File: rtl/ts_trigger_gen.sv
// Trigger conditioning: synchronises an external trigger, selects edges and
// turns each accepted event into one delayed, width-controlled pulse with holdoff.
module ts_trigger_gen #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic                 trig_in,
  input  logic                 sw_trig,
  input  logic                 cfg_enable,
  input  logic [1:0]           cfg_edge,
  input  logic                 cfg_mode,
  input  logic                 cfg_arm,
  input  logic [CNT_WIDTH-1:0] cfg_delay,
  input  logic [CNT_WIDTH-1:0] cfg_width,
  input  logic [CNT_WIDTH-1:0] cfg_holdoff,
  output logic                 trig_out,
  output logic                 trig_busy,
  output logic                 armed,
  output logic [31:0]          trig_count,
  output logic [15:0]          missed_count
);

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_PULSE, S_HOLDOFF} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t               r_state, w_state_nxt;
  logic [CNT_WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic [CNT_WIDTH-1:0] r_width, r_holdoff;
  logic [CNT_WIDTH-1:0] w_width_eff;
  logic                 r_s1, r_s2, r_s3;
  logic                 r_trig_out, r_armed;
  logic [31:0]          r_trig_count;
  logic [15:0]          r_missed_count, w_missed_nxt;
  logic                 w_rise, w_fall, w_edge_evt, w_event;
  logic                 w_accept, w_armed_nxt, w_pulse_start;

  assign w_rise = r_s2 & ~r_s3;
  assign w_fall = ~r_s2 & r_s3;

  always_comb begin
    w_edge_evt = 1'b0;
    case (cfg_edge)
      2'b00:   w_edge_evt = w_rise;
      2'b01:   w_edge_evt = w_fall;
      2'b10:   w_edge_evt = w_rise | w_fall;
      default: w_edge_evt = 1'b0;
    endcase
  end

  assign w_event     = w_edge_evt | sw_trig;
  assign w_accept    = (r_state == S_IDLE) & cfg_enable & (~cfg_mode | r_armed) & w_event;
  assign w_width_eff = (cfg_width == '0) ? CNT_ONE : cfg_width;

  // A zero delay skips DELAY, so the pulse width is taken straight from the config.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (!cfg_enable) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (cfg_delay != '0) begin
              w_state_nxt = S_DELAY;
              w_cnt_nxt   = cfg_delay;
            end else begin
              w_state_nxt = S_PULSE;
              w_cnt_nxt   = w_width_eff;
            end
          end
        end
        S_DELAY: begin
          if (r_cnt == CNT_ONE) begin
            w_state_nxt = S_PULSE;
            w_cnt_nxt   = r_width;
          end else begin
            w_cnt_nxt = r_cnt - CNT_ONE;
          end
        end
        S_PULSE: begin
          if (r_cnt == CNT_ONE) begin
            if (r_holdoff != '0) begin
              w_state_nxt = S_HOLDOFF;
              w_cnt_nxt   = r_holdoff;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_cnt_nxt = r_cnt - CNT_ONE;
          end
        end
        S_HOLDOFF: begin
          if (r_cnt == CNT_ONE) w_state_nxt = S_IDLE;
          else                  w_cnt_nxt   = r_cnt - CNT_ONE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign w_pulse_start = (w_state_nxt == S_PULSE) && (r_state != S_PULSE);

  // A new arm wins over the clear caused by a simultaneous single-shot acceptance.
  always_comb begin
    w_armed_nxt = r_armed;
    if (cfg_mode && cfg_arm)       w_armed_nxt = 1'b1;
    else if (cfg_mode && w_accept) w_armed_nxt = 1'b0;
  end

  always_comb begin
    w_missed_nxt = r_missed_count;
    if (w_event && cfg_enable && !w_accept && (r_missed_count != 16'hFFFF))
      w_missed_nxt = r_missed_count + 16'd1;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_s1           <= 1'b0;
      r_s2           <= 1'b0;
      r_s3           <= 1'b0;
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_width        <= '0;
      r_holdoff      <= '0;
      r_trig_out     <= 1'b0;
      r_armed        <= 1'b0;
      r_trig_count   <= '0;
      r_missed_count <= '0;
    end else begin
      r_s1           <= trig_in;
      r_s2           <= r_s1;
      r_s3           <= r_s2;
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      if (w_accept) begin
        r_width   <= w_width_eff;
        r_holdoff <= cfg_holdoff;
      end
      r_trig_out     <= (w_state_nxt == S_PULSE);
      r_armed        <= w_armed_nxt;
      r_trig_count   <= r_trig_count + {31'd0, w_pulse_start};
      r_missed_count <= w_missed_nxt;
    end
  end

  assign trig_out     = r_trig_out;
  assign trig_busy    = (r_state != S_IDLE);
  assign armed        = r_armed;
  assign trig_count   = r_trig_count;
  assign missed_count = r_missed_count;

endmodule

// File: tb/tb_ts_trigger_gen.sv
// Bench for ts_trigger_gen: timeline model of pulse windows checked every cycle,
// plus directed scenarios with literal expectations.
module tb_ts_trigger_gen;
  localparam int CW = 16;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic          trig_in = 1'b0;
  logic          sw_trig = 1'b0;
  logic          cfg_enable = 1'b0;
  logic [1:0]    cfg_edge = 2'b00;
  logic          cfg_mode = 1'b0;
  logic          cfg_arm = 1'b0;
  logic [CW-1:0] cfg_delay = '0;
  logic [CW-1:0] cfg_width = '0;
  logic [CW-1:0] cfg_holdoff = '0;
  logic          trig_out, trig_busy, armed;
  logic [31:0]   trig_count;
  logic [15:0]   missed_count;

  int checks = 0;
  int errors = 0;
  bit preload_req = 1'b0;

  ts_trigger_gen #(.CNT_WIDTH(CW)) dut (
    .aclk(aclk), .areset(areset), .trig_in(trig_in), .sw_trig(sw_trig),
    .cfg_enable(cfg_enable), .cfg_edge(cfg_edge), .cfg_mode(cfg_mode),
    .cfg_arm(cfg_arm), .cfg_delay(cfg_delay), .cfg_width(cfg_width),
    .cfg_holdoff(cfg_holdoff), .trig_out(trig_out), .trig_busy(trig_busy),
    .armed(armed), .trig_count(trig_count), .missed_count(missed_count)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: each acceptance at edge n schedules a pulse window [n+D, n+D+W)
  // and the return to idle at n+D+W+H; edges are numbered from 1.
  int          n = 0;
  int          m_idle_at = 0;
  int          m_pstart = -1;
  int          m_pend = -1;
  bit          m_s1, m_s2, m_s3, m_armed;
  logic [31:0] m_count = '0;
  logic [15:0] m_missed = '0;

  always @(posedge aclk) begin
    bit ev, acc, was_idle;
    int w;
    n++;
    if (areset) begin
      m_s1 = 0; m_s2 = 0; m_s3 = 0; m_armed = 0;
      m_count = '0; m_missed = '0;
      m_idle_at = n; m_pstart = -1; m_pend = -1;
    end else begin
      if (preload_req) begin
        m_count  = 32'hFFFF_FFFF;
        m_missed = 16'hFFFE;
      end
      case (cfg_edge)
        2'b00:   ev = m_s2 && !m_s3;
        2'b01:   ev = !m_s2 && m_s3;
        2'b10:   ev = m_s2 != m_s3;
        default: ev = 0;
      endcase
      ev = ev || sw_trig;
      was_idle = (n - 1) >= m_idle_at;
      acc = was_idle && cfg_enable && (!cfg_mode || m_armed) && ev;
      if (cfg_enable && ev && !acc && m_missed != 16'hFFFF) m_missed = m_missed + 16'd1;
      if (cfg_mode && cfg_arm) m_armed = 1;
      else if (cfg_mode && acc) m_armed = 0;
      if (!cfg_enable) begin
        m_idle_at = n; m_pstart = -1; m_pend = -1;
      end else if (acc) begin
        w = (cfg_width == 0) ? 1 : int'(cfg_width);
        m_pstart  = n + int'(cfg_delay);
        m_pend    = m_pstart + w;
        m_idle_at = m_pend + int'(cfg_holdoff);
      end
      if (n == m_pstart) m_count = m_count + 32'd1;
      m_s3 = m_s2; m_s2 = m_s1; m_s1 = trig_in;
    end
    #3;
    check("trig_out", trig_out, (m_pstart >= 0 && m_pstart <= n && n < m_pend) ? 1 : 0);
    check("trig_busy", trig_busy, (n < m_idle_at) ? 1 : 0);
    check("armed", armed, m_armed);
    check("trig_count", trig_count, m_count);
    check("missed_count", missed_count, m_missed);
  end

  task automatic tick(input int k);
    repeat (k) @(negedge aclk);
  endtask

  task automatic do_reset();
    areset = 1'b1;
    tick(2);
    areset = 1'b0;
    tick(1);
  endtask

  task automatic sw_pulse();
    sw_trig = 1'b1;
    tick(1);
    sw_trig = 1'b0;
  endtask

  initial begin
    tick(3);
    check("rst_out", trig_out, 0);
    check("rst_busy", trig_busy, 0);
    check("rst_count", trig_count, 0);
    check("rst_missed", missed_count, 0);
    areset = 1'b0;

    // Rising edge, continuous, D=0 W=4 H=0
    cfg_enable = 1; cfg_edge = 2'b00; cfg_mode = 0;
    cfg_delay = 0; cfg_width = 4; cfg_holdoff = 0;
    tick(2);
    trig_in = 1;
    tick(2);
    check("t1_before", trig_out, 0);
    tick(1);
    check("t1_rise", trig_out, 1);
    check("t1_busy", trig_busy, 1);
    check("t1_count", trig_count, 1);
    tick(3);
    check("t1_last", trig_out, 1);
    tick(1);
    check("t1_end", trig_out, 0);
    check("t1_idle", trig_busy, 0);
    trig_in = 0;
    tick(5);

    // Delay/holdoff with a rejected second sw_trig
    do_reset();
    cfg_delay = 10; cfg_width = 1; cfg_holdoff = 20;
    sw_pulse();
    tick(9);
    check("t2_pre", trig_out, 0);
    tick(1);
    check("t2_pulse", trig_out, 1);
    tick(1);
    check("t2_post", trig_out, 0);
    tick(3);
    sw_pulse();
    tick(15);
    check("t2_busy_last", trig_busy, 1);
    tick(1);
    check("t2_idle", trig_busy, 0);
    check("t2_missed", missed_count, 1);
    check("t2_count", trig_count, 1);
    tick(5);

    // Single-shot: unarmed edges are missed, arm lets exactly one through
    do_reset();
    cfg_mode = 1; cfg_delay = 0; cfg_width = 2; cfg_holdoff = 0;
    repeat (3) begin trig_in = 1; tick(4); trig_in = 0; tick(4); end
    check("t3_missed", missed_count, 3);
    check("t3_count", trig_count, 0);
    cfg_arm = 1; tick(1); cfg_arm = 0; tick(1);
    check("t3_armed", armed, 1);
    repeat (2) begin trig_in = 1; tick(4); trig_in = 0; tick(4); end
    check("t3_count2", trig_count, 1);
    check("t3_disarmed", armed, 0);
    check("t3_missed2", missed_count, 4);

    // Both edges, then no edges
    do_reset();
    cfg_mode = 0; cfg_edge = 2'b10; cfg_width = 2;
    repeat (8) begin trig_in = 1; tick(8); trig_in = 0; tick(8); end
    tick(4);
    check("t4_count", trig_count, 16);
    cfg_edge = 2'b11;
    repeat (2) begin trig_in = 1; tick(8); trig_in = 0; tick(8); end
    check("t4_none", trig_count, 16);
    check("t4_missed", missed_count, 0);

    // Abort mid-delay, then a normal run
    do_reset();
    cfg_edge = 2'b00; cfg_delay = 100; cfg_width = 3; cfg_holdoff = 0;
    sw_pulse();
    tick(49);
    check("t5_busy", trig_busy, 1);
    cfg_enable = 0;
    tick(1);
    check("t5_abort", trig_busy, 0);
    sw_pulse();
    tick(60);
    check("t5_nopulse", trig_count, 0);
    check("t5_nomiss", missed_count, 0);
    cfg_enable = 1;
    tick(1);
    sw_pulse();
    tick(99);
    check("t5_pre", trig_out, 0);
    tick(1);
    check("t5_pulse", trig_out, 1);
    check("t5_count", trig_count, 1);
    tick(5);

    // Counter wrap and saturation
    do_reset();
    cfg_delay = 0; cfg_width = 1; cfg_holdoff = 5;
    force dut.r_trig_count = 32'hFFFF_FFFF;
    force dut.r_missed_count = 16'hFFFE;
    preload_req = 1;
    tick(1);
    preload_req = 0;
    tick(1);
    release dut.r_trig_count;
    release dut.r_missed_count;
    tick(1);
    check("t6_pre_count", trig_count, 32'hFFFF_FFFF);
    check("t6_pre_missed", missed_count, 16'hFFFE);
    sw_trig = 1;
    tick(4);
    sw_trig = 0;
    tick(8);
    check("t6_wrap", trig_count, 0);
    check("t6_sat", missed_count, 16'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
